expr_stim_misr: RTL and testbench

Self-checking regression harness block that drives the 12 operand inputs of a vloghammer expression DUT and compacts the 90-bit y result bus into a signature. It generates pseudo-random operand vectors from a 60-bit LFSR and feeds each returned y into a 90-bit MISR. It sits beside the DUT in the hammer top level, and the final signature is compared against the golden-model signature.

---
 rtl/expr_harness_pkg.sv | 44 ++++
 rtl/expr_misr.sv | 33 +++
 rtl/expr_stim_misr.sv | 152 +++++++++++++++
 tb/tb_expr_stim_misr.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/expr_harness_pkg.sv
// Shared constants and types for the expression-hammer stimulus/signature harness.
// Holds the stimulus word layout, FSM encoding, LFSR taps and default MISR polynomial.
package expr_harness_pkg;

  localparam int STIM_W = 60;
  localparam int Y_W    = 90;

  localparam int W_S = 4;
  localparam int W_M = 5;
  localparam int W_L = 6;

  // Operand slices of the stimulus word, a0 occupying the MSBs.
  localparam int A0_LSB = 56;
  localparam int A1_LSB = 51;
  localparam int A2_LSB = 45;
  localparam int A3_LSB = 41;
  localparam int A4_LSB = 36;
  localparam int A5_LSB = 30;
  localparam int B0_LSB = 26;
  localparam int B1_LSB = 21;
  localparam int B2_LSB = 15;
  localparam int B3_LSB = 11;
  localparam int B4_LSB = 6;
  localparam int B5_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int LFSR_TAP_HI = 59;
  localparam int LFSR_TAP_LO = 58;
  localparam logic [STIM_W-1:0] LFSR_ZERO_SEED = 60'h1;

  localparam logic [Y_W-1:0] DEFAULT_POLY = 90'h47;

  // x^60 + x^59 + 1, Fibonacci form shifting toward the MSB.
  function automatic logic [STIM_W-1:0] lfsr_next(input logic [STIM_W-1:0] s);
    return {s[STIM_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/expr_misr.sv
// 90-bit Galois MISR: init reloads INIT, en folds one data word into the signature.
// Shared with the receive-side checker, so it carries no harness-specific logic.
module expr_misr
  import expr_harness_pkg::*;
#(
  parameter logic [Y_W-1:0] POLY = DEFAULT_POLY,
  parameter logic [Y_W-1:0] INIT = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           init,
  input  logic           en,
  input  logic [Y_W-1:0] data,
  output logic [Y_W-1:0] sig
);

  logic [Y_W-1:0] shifted;

  always_comb begin
    shifted = {sig[Y_W-2:0], 1'b0} ^ (sig[Y_W-1] ? POLY : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig <= INIT;
    end else if (init) begin
      sig <= INIT;
    end else if (en) begin
      sig <= shifted ^ data;
    end
  end

endmodule

// File: rtl/expr_stim_misr.sv
// Drives LFSR operand vectors into an expression DUT and compacts its y bus into a MISR.
// state    | meaning
// ST_IDLE  | waiting for start; signature and vec_cnt hold the last run
// ST_RUN   | one operand vector issued per cycle until num_vec reached
// ST_DRAIN | operands held while the DUT_LAT capture pipe empties
// ST_DONE  | one-cycle done pulse, then back to idle
module expr_stim_misr
  import expr_harness_pkg::*;
#(
  parameter int             CNT_W     = 16,
  parameter int             DUT_LAT   = 0,
  parameter logic [Y_W-1:0] MISR_INIT = '0,
  parameter logic [Y_W-1:0] POLY      = DEFAULT_POLY
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [STIM_W-1:0]       seed,
  input  logic [CNT_W-1:0]        num_vec,
  output logic [W_S-1:0]          a0,
  output logic [W_M-1:0]          a1,
  output logic [W_L-1:0]          a2,
  output logic signed [W_S-1:0]   a3,
  output logic signed [W_M-1:0]   a4,
  output logic signed [W_L-1:0]   a5,
  output logic [W_S-1:0]          b0,
  output logic [W_M-1:0]          b1,
  output logic [W_L-1:0]          b2,
  output logic signed [W_S-1:0]   b3,
  output logic signed [W_M-1:0]   b4,
  output logic signed [W_L-1:0]   b5,
  input  logic [Y_W-1:0]          y,
  output logic                    busy,
  output logic                    done,
  output logic [Y_W-1:0]          signature,
  output logic [CNT_W-1:0]        vec_cnt
);

  localparam logic [1:0] DRAIN_LOAD = 2'(DUT_LAT);

  state_t              state_q, state_d;
  logic [STIM_W-1:0]   lfsr_q;
  logic [STIM_W-1:0]   stim_q;
  logic [CNT_W-1:0]    num_vec_q;
  logic [CNT_W-1:0]    cnt_inc;
  logic [1:0]          drain_cnt_q;
  logic                vec_valid_q;
  logic                cap_valid;
  logic                accept;
  logic                issue;

  assign cnt_inc = vec_cnt + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (num_vec == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        issue = 1'b1;
        if (cnt_inc == num_vec_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt_q == 2'd0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= '0;
      stim_q      <= '0;
      num_vec_q   <= '0;
      vec_cnt     <= '0;
      vec_valid_q <= 1'b0;
      drain_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      vec_valid_q <= issue;
      if (accept) begin
        lfsr_q    <= (seed == '0) ? LFSR_ZERO_SEED : seed;
        num_vec_q <= num_vec;
        vec_cnt   <= '0;
      end else if (issue) begin
        stim_q  <= lfsr_q;
        lfsr_q  <= lfsr_next(lfsr_q);
        vec_cnt <= cnt_inc;
      end
      // Reloaded every RUN cycle so DRAIN always starts from the full latency.
      if (state_q == ST_RUN) begin
        drain_cnt_q <= DRAIN_LOAD;
      end else if (state_q == ST_DRAIN && drain_cnt_q != 2'd0) begin
        drain_cnt_q <= drain_cnt_q - 2'd1;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  generate
    if (DUT_LAT == 0) begin : g_nolat
      assign cap_valid = vec_valid_q;
    end else begin : g_lat
      logic [DUT_LAT-1:0] pipe_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pipe_q <= '0;
        end else begin
          pipe_q[0] <= vec_valid_q;
          for (int i = 1; i < DUT_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign cap_valid = pipe_q[DUT_LAT-1];
    end
  endgenerate

  expr_misr #(
    .POLY (POLY),
    .INIT (MISR_INIT)
  ) u_misr (
    .clk   (clk),
    .reset (reset),
    .init  (accept),
    .en    (cap_valid),
    .data  (y),
    .sig   (signature)
  );

  assign a0 = stim_q[A0_LSB +: W_S];
  assign a1 = stim_q[A1_LSB +: W_M];
  assign a2 = stim_q[A2_LSB +: W_L];
  assign a3 = $signed(stim_q[A3_LSB +: W_S]);
  assign a4 = $signed(stim_q[A4_LSB +: W_M]);
  assign a5 = $signed(stim_q[A5_LSB +: W_L]);
  assign b0 = stim_q[B0_LSB +: W_S];
  assign b1 = stim_q[B1_LSB +: W_M];
  assign b2 = stim_q[B2_LSB +: W_L];
  assign b3 = $signed(stim_q[B3_LSB +: W_S]);
  assign b4 = $signed(stim_q[B4_LSB +: W_M]);
  assign b5 = $signed(stim_q[B5_LSB +: W_L]);

endmodule

// File: tb/tb_expr_stim_misr.sv
// Bench for expr_stim_misr: a DUT_LAT=0 and a DUT_LAT=2 instance checked each cycle
// against a run model built from seed/num_vec with plain LFSR and MISR arithmetic.
module tb_expr_stim_misr;

  localparam logic [89:0] POLY_M = 90'h47;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start2 = 1'b0;
  logic [59:0] seed = '0;
  logic [15:0] num_vec = '0;
  logic        ymode = 1'b0;

  logic [3:0] d0_a0, d0_b0, d2_a0, d2_b0;
  logic [4:0] d0_a1, d0_b1, d2_a1, d2_b1;
  logic [5:0] d0_a2, d0_b2, d2_a2, d2_b2;
  logic signed [3:0] d0_a3, d0_b3, d2_a3, d2_b3;
  logic signed [4:0] d0_a4, d0_b4, d2_a4, d2_b4;
  logic signed [5:0] d0_a5, d0_b5, d2_a5, d2_b5;
  logic        busy0, done0, busy2, done2;
  logic [89:0] sig0, sig2, y0, y2;
  logic [15:0] cnt0, cnt2;
  logic [59:0] ops0, ops2, y2_r1 = '0;
  logic [89:0] y2_r2 = '0;

  assign ops0 = {d0_a0, d0_a1, d0_a2, d0_a3, d0_a4, d0_a5, d0_b0, d0_b1, d0_b2, d0_b3, d0_b4, d0_b5};
  assign ops2 = {d2_a0, d2_a1, d2_a2, d2_a3, d2_a4, d2_a5, d2_b0, d2_b1, d2_b2, d2_b3, d2_b4, d2_b5};
  assign y0 = ymode ? {30'h0, ops0} : 90'h3;
  assign y2 = y2_r2;

  // Two-stage DUT model behind the DUT_LAT=2 instance.
  always @(posedge clk) begin
    y2_r1 <= ops2;
    y2_r2 <= {30'h0, y2_r1};
  end

  always #5 clk = ~clk;

  expr_stim_misr #(.CNT_W(16), .DUT_LAT(0), .MISR_INIT(90'h0), .POLY(90'h47)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .seed(seed), .num_vec(num_vec),
    .a0(d0_a0), .a1(d0_a1), .a2(d0_a2), .a3(d0_a3), .a4(d0_a4), .a5(d0_a5),
    .b0(d0_b0), .b1(d0_b1), .b2(d0_b2), .b3(d0_b3), .b4(d0_b4), .b5(d0_b5),
    .y(y0), .busy(busy0), .done(done0), .signature(sig0), .vec_cnt(cnt0));

  expr_stim_misr #(.CNT_W(16), .DUT_LAT(2), .MISR_INIT(90'h0), .POLY(90'h47)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .seed(seed), .num_vec(num_vec),
    .a0(d2_a0), .a1(d2_a1), .a2(d2_a2), .a3(d2_a3), .a4(d2_a4), .a5(d2_a5),
    .b0(d2_b0), .b1(d2_b1), .b2(d2_b2), .b3(d2_b3), .b4(d2_b4), .b5(d2_b5),
    .y(y2), .busy(busy2), .done(done2), .signature(sig2), .vec_cnt(cnt2));

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [89:0] act, input logic [89:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Run model: vectors and signature after i captures, indexed by vector number.
  bit          m_run = 1'b0;
  int          m_sel = 0, m_N = 0, m_L = 0, m_c0 = 0;
  logic [59:0] m_vec [0:15];
  logic [89:0] m_sig [0:15];
  logic [59:0] m_prev = '0;
  int          done_cnt = 0, busy_cnt = 0, done_k = -1;

  logic [59:0] s_ops;
  logic        s_busy, s_done;
  logic [89:0] s_sig;
  logic [15:0] s_cnt;
  assign s_ops  = (m_sel != 0) ? ops2  : ops0;
  assign s_busy = (m_sel != 0) ? busy2 : busy0;
  assign s_done = (m_sel != 0) ? done2 : done0;
  assign s_sig  = (m_sel != 0) ? sig2  : sig0;
  assign s_cnt  = (m_sel != 0) ? cnt2  : cnt0;

  always @(negedge clk) begin
    logic [59:0] e_ops;
    logic        e_busy, e_done;
    logic [89:0] e_sig;
    int          e_cnt, k, d, nc;
    k = 0;
    if (!m_run) begin
      e_ops = '0; e_busy = 1'b0; e_done = 1'b0; e_sig = '0; e_cnt = 0;
    end else begin
      k = cyc - m_c0;
      d = (m_N == 0) ? 0 : m_N + m_L + 1;
      e_busy = (k <= d);
      e_done = (k == d);
      e_cnt = (k < m_N) ? k : m_N;
      e_ops = (k == 0 || m_N == 0) ? m_prev : m_vec[e_cnt];
      nc = k - 1 - m_L;
      if (nc < 0) nc = 0;
      if (nc > m_N) nc = m_N;
      e_sig = m_sig[nc];
    end
    if (s_done) begin done_cnt++; done_k = k; end
    if (s_busy) busy_cnt++;
    check("cyc_ops", {30'h0, s_ops}, {30'h0, e_ops});
    check("cyc_busy", {89'h0, s_busy}, {89'h0, e_busy});
    check("cyc_done", {89'h0, s_done}, {89'h0, e_done});
    check("cyc_sig", s_sig, e_sig);
    check("cyc_cnt", {74'h0, s_cnt}, 90'(e_cnt));
  end

  task automatic run_start(input int sel, input logic [59:0] sd, input int n, input bit ym);
    logic [59:0] fin, v;
    logic [89:0] yv;
    fin = (m_N > 0) ? m_vec[m_N] : m_prev;
    @(posedge clk); #2;
    ymode = ym; seed = sd; num_vec = 16'(n);
    if (sel != 0) start2 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start2 = 1'b0;
    m_prev = (m_run && m_sel == sel) ? fin : '0;
    m_sel = sel; m_N = n; m_L = (sel != 0) ? 2 : 0; m_c0 = cyc;
    v = (sd == '0) ? 60'h1 : sd;
    m_sig[0] = '0;
    for (int i = 1; i <= n; i++) begin
      m_vec[i] = v;
      yv = ym ? {30'h0, v} : 90'h3;
      m_sig[i] = ({m_sig[i-1][88:0], 1'b0} ^ (m_sig[i-1][89] ? POLY_M : 90'h0)) ^ yv;
      v = {v[58:0], v[59] ^ v[58]};
    end
    done_cnt = 0; busy_cnt = 0; done_k = -1;
    m_run = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #20;
    check("rst_ops0", {30'h0, ops0}, 90'h0);
    check("rst_sig2", sig2, 90'h0);
    check("rst_busy0", {89'h0, busy0}, 90'h0);
    #2 reset = 1'b0;

    // seed 0 is replaced by 1: only b5 is nonzero
    run_start(0, 60'h0, 1, 1'b1);
    repeat (5) @(posedge clk); #2;
    check("s0_model_vec", {30'h0, m_vec[1]}, 90'h1);
    check("s0_b5", {84'h0, d0_b5}, 90'h1);
    check("s0_ops", {30'h0, ops0}, 90'h1);
    check("s0_cnt", {74'h0, cnt0}, 90'h1);
    check("s0_done_k", 90'(done_k), 90'd2);
    check("s0_done_cnt", 90'(done_cnt), 90'd1);

    run_start(0, 60'h0, 1, 1'b0);
    repeat (5) @(posedge clk); #2;
    check("y3_n1_sig", sig0, 90'h3);

    run_start(0, 60'h0, 2, 1'b0);
    repeat (6) @(posedge clk); #2;
    check("y3_n2_model", m_sig[2], 90'h5);
    check("y3_n2_sig", sig0, 90'h5);

    run_start(0, 60'h5A5, 0, 1'b1);
    repeat (4) @(posedge clk); #2;
    check("n0_sig", sig0, 90'h0);
    check("n0_ops", {30'h0, ops0}, 90'h2);
    check("n0_busy_cnt", 90'(busy_cnt), 90'd1);
    check("n0_done_cnt", 90'(done_cnt), 90'd1);
    check("n0_done_k", 90'(done_k), 90'd0);

    // start while busy must be ignored
    run_start(0, 60'hDEA_DBEE_F123_4567, 10, 1'b1);
    repeat (3) @(posedge clk); #2;
    seed = 60'hABC; num_vec = 16'd3; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (10) @(posedge clk); #2;
    check("ign_cnt", {74'h0, cnt0}, 90'd10);
    check("ign_done_cnt", 90'(done_cnt), 90'd1);
    check("ign_done_k", 90'(done_k), 90'd11);

    // asynchronous reset in the middle of a run
    run_start(0, 60'h0F0_F0F0_F0F0_F0F0, 10, 1'b1);
    repeat (5) @(posedge clk); #2;
    reset = 1'b1; m_run = 1'b0; done_cnt = 0;
    #1;
    check("ar_ops", {30'h0, ops0}, 90'h0);
    check("ar_busy", {89'h0, busy0}, 90'h0);
    check("ar_sig", sig0, 90'h0);
    check("ar_cnt", {74'h0, cnt0}, 90'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (4) @(posedge clk); #2;
    check("ar_no_done", 90'(done_cnt), 90'd0);

    run_start(0, 60'h123_4567_89AB_CDEF, 5, 1'b1);
    repeat (9) @(posedge clk); #2;
    check("fresh_cnt", {74'h0, cnt0}, 90'd5);
    check("fresh_done_k", 90'(done_k), 90'd6);
    check("fresh_done_cnt", 90'(done_cnt), 90'd1);

    // two-cycle DUT latency
    run_start(1, 60'hFED_CBA9_8765_4321, 4, 1'b1);
    repeat (10) @(posedge clk); #2;
    check("lat2_done_k", 90'(done_k), 90'd7);
    check("lat2_done_cnt", 90'(done_cnt), 90'd1);
    check("lat2_cnt", {74'h0, cnt2}, 90'd4);
    check("lat2_sig", sig2, m_sig[4]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
